text_loader_ctrl: RTL



---
 rtl/text_loader_ctrl_pkg.sv | 26 ++
 rtl/text_loader_ctrl_if.sv | 11 +
 rtl/text_loader_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/text_loader_ctrl_pkg.sv
// Shared types and constants for the boot-time text-memory loader controller.
package text_loader_pkg;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam logic [7:0] DEFAULT_MAGIC     = 8'hA5;
  localparam int         DEFAULT_MAX_WORDS = 256;

  // Byte acceptance depends on state alone so in_ready never waits on in_valid.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/text_loader_ctrl_if.sv
// Byte-serial valid/ready stream feeding the loader controller.
interface text_loader_ctrl_if;

  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input  in_ready);
  modport slave  (input  in_byte, input  in_valid, output in_ready);

endinterface

// File: rtl/text_loader_ctrl.sv
// Parses a framed byte stream (magic, LE word count, payload, XOR checksum) into
// text-memory byte writes and holds the core in reset until a good load completes.
module text_loader_ctrl
  import text_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC     = DEFAULT_MAGIC,
  parameter int         MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int         LEN_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  text_loader_ctrl_if.slave  in_if,
  input  logic               start,
  output logic               mem_clr,
  output logic               mem_we,
  output logic [7:0]         mem_data,
  output logic               cpu_hold,
  output logic               done,
  output logic [1:0]         err_code,
  output logic [LEN_W-1:0]   loaded_words
);

  localparam int CNT_W = $clog2(4 * MAX_WORDS) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       err_q, err_d;
  logic [LEN_W-1:0] loaded_q, loaded_d;
  logic             mem_clr_q, mem_clr_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_data_q, mem_data_d;

  logic             in_ready_w;
  logic             hs;
  logic [CNT_W-1:0] byte_tgt;

  assign in_ready_w = accepts_bytes(state_q);
  assign hs         = in_if.in_valid & in_ready_w;
  // Safe to truncate: lengths above MAX_WORDS never reach DATA.
  assign byte_tgt   = {len_q[CNT_W-3:0], 2'b00};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    len_d      = len_q;
    err_d      = err_q;
    loaded_d   = loaded_q;
    mem_clr_d  = 1'b0;
    mem_we_d   = 1'b0;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_CLR: begin
        mem_clr_d = 1'b1;
        cnt_d     = '0;
        csum_d    = '0;
        len_d     = '0;
        state_d   = ST_SYNC;
      end
      ST_SYNC: begin
        if (hs && (in_if.in_byte == MAGIC)) begin
          cnt_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (hs) begin
          len_d[{cnt_q[1:0], 3'b000} +: 8] = in_if.in_byte;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d = '0;
            if (len_d > LEN_W'(MAX_WORDS)) begin
              err_d   = ERR_LEN;
              state_d = ST_ERR;
            end else if (len_d == '0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          mem_we_d   = 1'b1;
          mem_data_d = in_if.in_byte;
          csum_d     = csum_q ^ in_if.in_byte;
          if (cnt_q == byte_tgt - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_CSUM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (in_if.in_byte == csum_q) begin
            loaded_d = len_q;
            state_d  = ST_DONE;
          end else begin
            err_d   = ERR_CSUM;
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          err_d   = ERR_NONE;
          state_d = ST_CLR;
        end
      end
      default: state_d = ST_CLR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLR;
      cnt_q      <= '0;
      csum_q     <= '0;
      len_q      <= '0;
      err_q      <= ERR_NONE;
      loaded_q   <= '0;
      mem_clr_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      err_q      <= err_d;
      loaded_q   <= loaded_d;
      mem_clr_q  <= mem_clr_d;
      mem_we_q   <= mem_we_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign in_if.in_ready = in_ready_w;
  assign mem_clr        = mem_clr_q;
  assign mem_we         = mem_we_q;
  assign mem_data       = mem_data_q;
  assign cpu_hold       = (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign err_code       = err_q;
  assign loaded_words   = loaded_q;

endmodule
